zbuf_clear: RTL and testbench
=============================

// Module: zbuf_clear
// PURPOSE
//  Write-side companion to the per-pixel depth test: sweeps the 320x240 z-buffer BRAM
//  (port A) and writes CLEAR_VAL (farthest depth) into every cell of a requested rectangle.
//  Run once per frame, before rasterization, so depth compares start from "infinitely far".
//  Shares BRAM port A with the depth-test write path via mem_req/mem_gnt; holds off the
//  rasterizer with frag_ready while sweeping.
// PARAMETERS
//  H_RES       320    pixels per row; address = y*H_RES + x
//  V_RES       240    rows
//  Z_WIDTH     8      depth word width
//  ADDR_WIDTH  20     BRAM address width
//  CLEAR_VAL   8'hFF  value written (max depth)
// PORTS
//  clk         in   1           single clock, all logic rising-edge
//  reset       in   1           synchronous, active-high
//  start       in   1           1-cycle request; rect latched on this cycle
//  x0,x1       in   9           inclusive column bounds
//  y0,y1       in   8           inclusive row bounds
//  busy        out  1           high from cycle after accepted start until done
//  done        out  1           1-cycle pulse at end of operation
//  frag_ready  out  1           low while busy; rasterizer must stall
//  mem_req     out  1           request for BRAM port A, high throughout SWEEP
//  mem_gnt     in   1           arbiter grant; a write happens only in cycles where high
//  ena         out  1           BRAM port-A enable
//  wea         out  4           BRAM write enable, 4'hF when writing else 0
//  addra       out  ADDR_WIDTH  BRAM address (registered)
//  dina        out  Z_WIDTH     constant CLEAR_VAL
// BEHAVIOUR
//  - Reset values: busy=0 done=0 frag_ready=1 mem_req=0 ena=0 wea=0 addra=0; state IDLE.
//  - States: IDLE, SWEEP, DONE.
//  - IDLE: on start, clamp x1 to H_RES-1, y1 to V_RES-1; latch bounds; x=x0, y=y0,
//    row_base=y0*H_RES (single multiply at start only), addra=row_base+x0.
//    If x0>x1 or y0>y1 (after clamp) -> DONE directly, zero writes. Else -> SWEEP.
//  - SWEEP: mem_req=1, busy=1, frag_ready=0. ena=wea-active = mem_gnt (combinational).
//    On a granted cycle: write addra; advance x; at x==x1 wrap x=x0, row_base+=H_RES, y++.
//    Addresses are generated incrementally (add, no per-pixel multiply).
//    mem_gnt=0: no write, counters/addra hold. Last write (x==x1 && y==y1 && mem_gnt) -> DONE.
//  - DONE: done=1 for exactly one cycle, busy=0, mem_req=0, frag_ready=1; -> IDLE.
//  - Timing, grant held high: start at cycle 0 -> writes cycles 1..N -> done at N+1,
//    N=(x1-x0+1)*(y1-y0+1). Full screen: N=76800, done at cycle 76801.
//  - start while busy or in DONE: ignored, no queuing.
//  - reset mid-SWEEP: aborts next edge; outputs return to reset values; no done pulse;
//    cells not yet written keep old contents.
//  - Addresses never exceed H_RES*V_RES-1; the same address is never written twice
//    in one operation.
// STRUCTURE
//  - zbuf_pkg: H_RES, V_RES, Z_WIDTH, ZBUF_ADDR_W, Z_FAR (=CLEAR_VAL), and
//    typedef enum logic [1:0] {ZC_IDLE, ZC_SWEEP, ZC_DONE} zc_state_t.
//    Shared with the depth-test block and the port-A arbiter.
//  - One sub-module: zbuf_rect_addr_gen (x/y counters, row_base accumulator, last flag,
//    advance input = granted write). FSM and port drive stay in zbuf_clear.
// TESTING
//  1 full clear: start, rect (0,0)-(319,239), gnt=1 -> 76800 writes of 8'hFF, addra 0..76799 ascending, done @ cycle 76801.
//  2 small rect (10,5)-(11,6) -> writes exactly to 1610,1611,1930,1931 in that order; done 1 cycle after last write.
//  3 grant toggling 1,0 each cycle on rect (0,0)-(3,0) -> 4 writes, none while gnt=0, addra held across stalls, done @ cycle 8.
//  4 degenerate x0=5,x1=4 -> zero wea cycles, done pulse cycle 1, busy never 1; clamp x1=400 on row 0 -> last addr 319.
//  5 start pulsed again mid-sweep -> ignored; one done pulse only, write count unchanged.
//  6 reset after 100 writes of full clear -> next cycle busy=0 mem_req=0 wea=0 frag_ready=1; no done; addr 100+ untouched in BRAM model.

Source files
------------

// File: rtl/zbuf_pkg.sv
// zbuf_pkg: z-buffer geometry, depth word, far-plane value and clear FSM states
package zbuf_pkg;
    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int Z_WIDTH = 8;
    localparam int ZBUF_ADDR_W = 20;
    localparam logic [Z_WIDTH-1:0] Z_FAR = 8'hFF;
    localparam logic [8:0] X_MAX = 9'(H_RES - 1);
    localparam logic [7:0] Y_MAX = 8'(V_RES - 1);
    localparam logic [ZBUF_ADDR_W-1:0] ROW_STEP = ZBUF_ADDR_W'(H_RES);
    typedef enum logic [1:0] {ZC_IDLE, ZC_SWEEP, ZC_DONE} zc_state_t;
endpackage

// File: rtl/zbuf_rect_addr_gen.sv
// zbuf_rect_addr_gen: raster-order address walker over a rectangle, one step per granted write
module zbuf_rect_addr_gen
    import zbuf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [8:0]             x0,
    input  logic [8:0]             x1,
    input  logic [7:0]             y0,
    input  logic [7:0]             y1,
    output logic [ZBUF_ADDR_W-1:0] addr,
    output logic                   last
);
    logic [8:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [7:0] y_q, y_d, y1_q, y1_d;
    logic [ZBUF_ADDR_W-1:0] rb_q, rb_d, addr_q, addr_d;
    // Load computes the first row base once; afterwards rows advance by adding H_RES
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        x0_d = x0_q;
        x1_d = x1_q;
        y1_d = y1_q;
        rb_d = rb_q;
        addr_d = addr_q;
        if (load) begin
            x0_d = x0;
            x1_d = x1;
            y1_d = y1;
            x_d = x0;
            y_d = y0;
            rb_d = ZBUF_ADDR_W'(y0) * ROW_STEP;
            addr_d = rb_d + ZBUF_ADDR_W'(x0);
        end else if (advance) begin
            if (x_q == x1_q) begin
                x_d = x0_q;
                y_d = y_q + 8'd1;
                rb_d = rb_q + ROW_STEP;
                addr_d = rb_d + ZBUF_ADDR_W'(x0_q);
            end else begin
                x_d = x_q + 9'd1;
                addr_d = addr_q + ZBUF_ADDR_W'(1);
            end
        end
    end
    // Counter and address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            rb_q <= '0;
            addr_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
            rb_q <= rb_d;
            addr_q <= addr_d;
        end
    end
    assign addr = addr_q;
    assign last = (x_q == x1_q) && (y_q == y1_q);
endmodule

// File: rtl/zbuf_clear.sv
// zbuf_clear: fills a rectangle of the z-buffer with the far depth before rasterization
module zbuf_clear
    import zbuf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8:0]             x0,
    input  logic [8:0]             x1,
    input  logic [7:0]             y0,
    input  logic [7:0]             y1,
    output logic                   busy,
    output logic                   done,
    output logic                   frag_ready,
    output logic                   mem_req,
    input  logic                   mem_gnt,
    output logic                   ena,
    output logic [3:0]             wea,
    output logic [ZBUF_ADDR_W-1:0] addra,
    output logic [Z_WIDTH-1:0]     dina
);
    zc_state_t state_q, state_d;
    logic [8:0] x1c;
    logic [7:0] y1c;
    logic empty, load, sweep, wr, last;
    assign x1c = (x1 > X_MAX) ? X_MAX : x1;
    assign y1c = (y1 > Y_MAX) ? Y_MAX : y1;
    assign empty = (x0 > x1c) || (y0 > y1c);
    assign sweep = (state_q == ZC_SWEEP);
    assign load = (state_q == ZC_IDLE) && start;
    assign wr = sweep && mem_gnt;
    // Next state: start only accepted in IDLE, empty rectangles skip straight to DONE
    always_comb begin
        state_d = state_q;
        state_d = (state_q == ZC_IDLE)  ? (start ? (empty ? ZC_DONE : ZC_SWEEP) : ZC_IDLE) :
                  (state_q == ZC_SWEEP) ? ((wr && last) ? ZC_DONE : ZC_SWEEP) :
                                          ZC_IDLE;
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ZC_IDLE;
        else state_q <= state_d;
    end
    zbuf_rect_addr_gen u_gen (
        .clk(clk),
        .reset(reset),
        .load(load),
        .advance(wr),
        .x0(x0),
        .x1(x1c),
        .y0(y0),
        .y1(y1c),
        .addr(addra),
        .last(last)
    );
    assign busy = sweep;
    assign mem_req = sweep;
    assign frag_ready = !sweep;
    assign done = (state_q == ZC_DONE);
    assign ena = wr;
    assign wea = {4{wr}};
    assign dina = Z_FAR;
endmodule

// File: tb/tb_zbuf_clear.sv
// tb_zbuf_clear: randomized and directed check of zbuf_clear against a pixel-list model
module tb_zbuf_clear;
    import zbuf_pkg::*;
    logic clk = 0, reset, start, mem_gnt;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic busy, done, frag_ready, mem_req, ena;
    logic [3:0] wea;
    logic [19:0] addra;
    logic [7:0] dina;
    int total = 0, bad = 0;
    int cyc = 0, cs = 0;
    int exp_q[$];
    bit m_active = 0, m_done = 0, chk_en = 0;
    logic [7:0] mem [0:76799];
    int n_wr, n_done, done_cyc, last_wr_cyc;
    int wr_log[$];
    bit busy_seen;

    always #5 clk = ~clk;

    zbuf_clear dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .busy(busy), .done(done), .frag_ready(frag_ready),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .ena(ena),
        .wea(wea), .addra(addra), .dina(dina)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // BRAM model and behavioural reference, advanced at each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (ena && wea == 4'hF && addra < 20'd76800) mem[addra] = dina;
        if (reset) begin
            exp_q.delete();
            m_active = 0;
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (mem_gnt) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end else if (start) begin
            int cx1, cy1;
            cx1 = (x1 > 319) ? 319 : int'(x1);
            cy1 = (y1 > 239) ? 239 : int'(y1);
            for (int y = y0; y <= cy1; y++)
                for (int x = x0; x <= cx1; x++) exp_q.push_back(y * H_RES + x);
            if (exp_q.size() == 0) m_done = 1;
            else m_active = 1;
        end
    end

    // Per-cycle compare against the model, plus write/done bookkeeping
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [36:0] a, e;
            logic ew;
            ew = m_active && mem_gnt;
            a = {busy, done, frag_ready, mem_req, ena, wea, dina, m_active ? addra : 20'd0};
            e = {m_active, m_done, !m_active, m_active, ew, ew ? 4'hF : 4'h0, 8'hFF,
                 m_active ? 20'(exp_q[0]) : 20'd0};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs: got %h want %h", cyc - cs + 1, a, e);
            end
            if (busy) busy_seen = 1;
            if (ena) begin
                n_wr++;
                wr_log.push_back(int'(addra));
                last_wr_cyc = cyc - cs + 1;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc - cs + 1;
            end
        end
    end

    // gmode: 0 grant held, 1 grant 1,0,1,0..., 2 random grant; inj: cycle to re-pulse start
    task automatic run_op(input string nm, input int ax0, input int ax1, input int ay0,
                          input int ay1, input int gmode, input int inj, input int maxc);
        n_wr = 0;
        n_done = 0;
        done_cyc = -1;
        last_wr_cyc = -1;
        wr_log.delete();
        busy_seen = 0;
        x0 = 9'(ax0);
        x1 = 9'(ax1);
        y0 = 8'(ay0);
        y1 = 8'(ay1);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        cs = cyc;
        for (int k = 1; k <= maxc && n_done == 0; k++) begin
            mem_gnt = (gmode == 0) ? 1'b1 : (gmode == 1) ? 1'(k % 2) : 1'($urandom_range(0, 1));
            start = (k == inj);
            @(posedge clk);
            #1;
        end
        start = 0;
        mem_gnt = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk({nm, "_done_count"}, n_done, 1);
    endtask

    initial begin
        int cnt, ordbad;
        reset = 1;
        start = 0;
        mem_gnt = 0;
        x0 = 0;
        x1 = 0;
        y0 = 0;
        y1 = 0;
        for (int i = 0; i < 76800; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frag_ready", frag_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ena_wea", {ena, wea}, 0);
        chk("rst_addra", addra, 0);

        run_op("full", 0, 319, 0, 239, 0, 0, 80000);
        chk("full_writes", n_wr, 76800);
        chk("full_done_cyc", done_cyc, 76801);
        ordbad = 0;
        foreach (wr_log[i]) if (wr_log[i] != i) ordbad++;
        chk("full_order", ordbad, 0);
        cnt = 0;
        for (int i = 0; i < 76800; i++) if (mem[i] == 8'hFF) cnt++;
        chk("full_mem_ff", cnt, 76800);

        run_op("small", 10, 11, 5, 6, 0, 0, 100);
        chk("small_writes", n_wr, 4);
        chk("small_a0", wr_log[0], 1610);
        chk("small_a1", wr_log[1], 1611);
        chk("small_a2", wr_log[2], 1930);
        chk("small_a3", wr_log[3], 1931);
        chk("small_done_after_last", done_cyc, last_wr_cyc + 1);

        run_op("toggle", 0, 3, 0, 0, 1, 0, 100);
        chk("toggle_writes", n_wr, 4);
        chk("toggle_done_cyc", done_cyc, 8);
        chk("toggle_last_addr", wr_log[3], 3);

        run_op("degen", 5, 4, 0, 0, 0, 0, 100);
        chk("degen_writes", n_wr, 0);
        chk("degen_done_cyc", done_cyc, 1);
        chk("degen_busy_seen", busy_seen, 0);

        run_op("clamp", 300, 400, 0, 0, 0, 0, 200);
        chk("clamp_writes", n_wr, 20);
        chk("clamp_last_addr", wr_log[19], 319);

        run_op("restart", 2, 6, 1, 2, 0, 3, 200);
        chk("restart_writes", n_wr, 10);

        for (int i = 0; i < 76800; i++) mem[i] = 8'h3C;
        n_wr = 0;
        n_done = 0;
        x0 = 0;
        x1 = 319;
        y0 = 0;
        y1 = 239;
        start = 1;
        mem_gnt = 1;
        @(posedge clk);
        #1;
        start = 0;
        cs = cyc;
        for (int k = 0; k < 300 && n_wr < 100; k++) begin
            @(posedge clk);
            #1;
        end
        reset = 1;
        mem_gnt = 0;
        @(posedge clk);
        #1;
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_wea", wea, 0);
        chk("abort_frag_ready", frag_ready, 1);
        chk("abort_addra", addra, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", n_done, 0);
        cnt = 0;
        for (int i = 0; i < 76800; i++) if (mem[i] == 8'hFF) cnt++;
        chk("abort_ff_cells", cnt, 100);
        chk("abort_cell99", mem[99], 8'hFF);
        chk("abort_cell100", mem[100], 8'h3C);

        for (int t = 0; t < 20; t++) begin
            int rx0, rx1, ry0, ry1, cx1, cy1, n;
            rx0 = $urandom_range(0, 330);
            rx1 = rx0 + $urandom_range(0, 12) - 2;
            if (rx1 < 0) rx1 = 0;
            ry0 = $urandom_range(0, 245);
            ry1 = ry0 + $urandom_range(0, 6) - 1;
            if (ry1 < 0) ry1 = 0;
            cx1 = (rx1 > 319) ? 319 : rx1;
            cy1 = (ry1 > 239) ? 239 : ry1;
            n = (cx1 >= rx0 && cy1 >= ry0) ? (cx1 - rx0 + 1) * (cy1 - ry0 + 1) : 0;
            run_op("rand", rx0, rx1, ry0, ry1, 2, $urandom_range(0, 8), 2000);
            chk("rand_writes", n_wr, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
